// File: rtl/frv_shift_seq_if.sv
// Dispatch/writeback handshake bundle for the iterative shift/rotate sequencer.
// master = dispatch + writeback side, slave = sequencer.
interface frv_shift_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_rs1;
   logic [4:0]  req_shamt;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;

   modport master (
      output req_valid, req_op, req_rs1, req_shamt, rsp_ready,
      input  req_ready, rsp_valid, rsp_result
   );

   modport slave (
      input  req_valid, req_op, req_rs1, req_shamt, rsp_ready,
      output req_ready, rsp_valid, rsp_result
   );
endinterface

// File: rtl/frv_shift_seq.sv
// Iterative SLL/SRL/SRA/ROR/ROL sequencer applying at most STEP bits of shift per RUN cycle.
// Optional macro FRV_SHIFT_SEQ_B2B_EN: accept a new request on the response handshake cycle.
module frv_shift_seq #(
   parameter int STEP = 4
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,
   input  logic                  flush,
   frv_shift_seq_if.slave        bus,
   output logic                  busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [4:0] STEP_AMT = 5'(STEP);

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  rem_q, rem_d;
   logic [2:0]  op_q, op_d;

   logic [4:0]  step_amt;
   logic [4:0]  rem_left;

   // Single partial shift; a zero amount leaves the operand untouched for every op.
   function automatic logic [31:0] step_fn(input logic [2:0] op, input logic [31:0] x,
                                           input logic [4:0] s);
      logic [5:0] inv;
      inv     = 6'd32 - {1'b0, s};
      step_fn = x;
      if (s != 5'd0) begin
         case (op)
            3'b000:  step_fn = x << s;
            3'b001:  step_fn = x >> s;
            3'b010:  step_fn = 32'($signed(x) >>> s);
            3'b011:  step_fn = (x >> s) | (x << inv);
            3'b100:  step_fn = (x << s) | (x >> inv);
            default: step_fn = x;
         endcase
      end
   endfunction

   assign step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
   assign rem_left = rem_q - step_amt;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      rem_d         = rem_q;
      op_d          = op_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;

      case (state_q)
         S_IDLE: begin
            bus.req_ready = !flush;
            if (flush) begin
               rem_d = '0;
            end else if (bus.req_valid) begin
               acc_d   = bus.req_rs1;
               op_d    = bus.req_op;
               rem_d   = bus.req_shamt;
               state_d = (bus.req_shamt == 5'd0 || bus.req_op > 3'b100) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
               rem_d   = '0;
            end else begin
               acc_d   = step_fn(op_q, acc_q, step_amt);
               rem_d   = rem_left;
               state_d = (rem_left == 5'd0) ? S_DONE : S_RUN;
            end
         end
         S_DONE: begin
            bus.rsp_valid = 1'b1;
`ifdef FRV_SHIFT_SEQ_B2B_EN
            bus.req_ready = bus.rsp_ready && !flush;
`endif
            if (flush) begin
               state_d = S_IDLE;
               rem_d   = '0;
            end else if (bus.rsp_ready) begin
               state_d = S_IDLE;
`ifdef FRV_SHIFT_SEQ_B2B_EN
               // Load the next operation straight out of DONE, skipping the IDLE bubble.
               if (bus.req_valid) begin
                  acc_d   = bus.req_rs1;
                  op_d    = bus.req_op;
                  rem_d   = bus.req_shamt;
                  state_d = (bus.req_shamt == 5'd0 || bus.req_op > 3'b100) ? S_DONE : S_RUN;
               end
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.rsp_result = acc_q;
   assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_frv_shift_seq.sv
// Self-checking bench for frv_shift_seq: directed vectors, random ops, stall, flush, reset, back-to-back.
module tb_frv_shift_seq;
   localparam int STEP = 4;

   logic g_clk = 1'b0;
   logic g_resetn;
   logic flush;
   logic busy;
   int   checks   = 0;
   int   failures = 0;

   frv_shift_seq_if bus ();

   frv_shift_seq #(.STEP(STEP)) dut (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .flush    (flush),
      .bus      (bus),
      .busy     (busy)
   );

   always #5 g_clk = ~g_clk;

   // Reference: whole-distance shift computed in one go, rotates via a doubled word.
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] x, input int sh);
      logic [63:0] dbl;
      logic [63:0] tmp;
      dbl = {x, x};
      case (op)
         3'd0: return x << sh;
         3'd1: return x >> sh;
         3'd2: return 32'($signed(x) >>> sh);
         3'd3: begin tmp = dbl >> sh; return tmp[31:0]; end
         3'd4: begin tmp = dbl << sh; return tmp[63:32]; end
         default: return x;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input int sh);
      if (op > 3'd4 || sh == 0) return 1;
      return 1 + (sh + STEP - 1) / STEP;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] rs1, input int sh,
                         input int stall, input string tag);
      int          cyc;
      int          lat;
      logic [31:0] exp;
      exp = ref_result(op, rs1, sh);
      lat = ref_latency(op, sh);
      @(negedge g_clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_idle got=%b want=1", tag, bus.req_ready);
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rs1   = rs1;
      bus.req_shamt = 5'(sh);
      @(negedge g_clk);
      bus.req_valid = 1'b0;
      bus.req_rs1   = $urandom;
      cyc = 1;
      while (bus.rsp_valid !== 1'b1 && cyc < 64) begin
         @(negedge g_clk);
         cyc++;
      end
      checks++;
      if (bus.rsp_valid !== 1'b1 || cyc != lat) begin
         failures++;
         $display("FAIL %s latency got=%0d want=%0d", tag, cyc, lat);
      end
      checks++;
      if (bus.rsp_result !== exp) begin
         failures++;
         $display("FAIL %s result got=%h want=%h", tag, bus.rsp_result, exp);
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge g_clk);
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== exp || bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s stall valid=%b result=%h ready=%b want valid=1 result=%h ready=0",
                     tag, bus.rsp_valid, bus.rsp_result, bus.req_ready, exp);
         end
      end
      bus.rsp_ready = 1'b1;
      @(negedge g_clk);
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s after_handshake valid=%b busy=%b want 0/0", tag, bus.rsp_valid, busy);
      end
      $display("TXN %s op=%0d rs1=%h sh=%0d stall=%0d result=%h lat=%0d",
               tag, op, rs1, sh, stall, exp, cyc);
   endtask

   task automatic test_reset();
      g_resetn = 1'b0;
      repeat (2) @(negedge g_clk);
      g_resetn = 1'b1;
      @(negedge g_clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset ready=%b valid=%b result=%h busy=%b want 1/0/0/0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_result, busy);
      end
      $display("TXN reset done");
   endtask

   task automatic test_directed();
      run_op(3'd3, 32'h80000001, 1,  0, "ror_1");
      run_op(3'd3, 32'h00000001, 31, 0, "rori_31");
      run_op(3'd2, 32'h80000000, 8,  0, "sra_8");
      run_op(3'd1, 32'h80000000, 8,  0, "srl_8");
      run_op(3'd4, 32'h80000000, 4,  0, "rol_4");
      run_op(3'd0, 32'hDEADBEEF, 0,  0, "sll_0");
      run_op(3'd3, 32'hDEADBEEF, 0,  0, "ror_0");
      run_op(3'd7, 32'hDEADBEEF, 17, 0, "pass_111");
      run_op(3'd0, 32'h00000001, 31, 0, "sll_31");
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         run_op(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 31),
                $urandom_range(0, 2), $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_stall();
      run_op(3'd3, 32'h12345678, 13, 3, "stall3");
   endtask

   task automatic test_flush();
      int seen;
      @(negedge g_clk);
      bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_rs1 = 32'hF0F0F0F0; bus.req_shamt = 5'd20;
      @(negedge g_clk);
      bus.req_valid = 1'b0;
      @(negedge g_clk);
      flush = 1'b1;
      @(negedge g_clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_run busy=%b valid=%b want 0/0", busy, bus.rsp_valid);
      end
      seen = 0;
      repeat (8) begin
         @(negedge g_clk);
         if (bus.rsp_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL flush_norsp rsp_cycles=%0d want 0", seen);
      end
      $display("TXN flush_run");

      flush = 1'b1;
      bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_shamt = 5'd3;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_ready got=%b want=0", bus.req_ready);
      end
      @(negedge g_clk);
      flush = 1'b0;
      bus.req_valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_accept busy=%b want=0", busy);
      end
      $display("TXN flush_idle");

      bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_rs1 = 32'h1; bus.req_shamt = 5'd0;
      @(negedge g_clk);
      bus.req_valid = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL flush_done_pre valid=%b want=1", bus.rsp_valid);
      end
      flush = 1'b1;
      @(negedge g_clk);
      flush = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_done valid=%b busy=%b want 0/0", bus.rsp_valid, busy);
      end
      $display("TXN flush_done");
   endtask

   task automatic test_reset_mid();
      @(negedge g_clk);
      bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_rs1 = 32'h12345678; bus.req_shamt = 5'd31;
      @(negedge g_clk);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge g_clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_pre busy=%b want=1", busy);
      end
      g_resetn = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid ready=%b valid=%b result=%h busy=%b want 1/0/0/0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_result, busy);
      end
      @(negedge g_clk);
      g_resetn = 1'b1;
      repeat (10) @(negedge g_clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_norsp valid=%b busy=%b want 0/0", bus.rsp_valid, busy);
      end
      $display("TXN reset_mid");
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
      a = $urandom;
      b = $urandom;
      @(negedge g_clk);
      bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_rs1 = a; bus.req_shamt = 5'd4;
      @(negedge g_clk);
      bus.req_valid = 1'b0;
      cyc = 1;
      while (bus.rsp_valid !== 1'b1 && cyc < 16) begin
         @(negedge g_clk);
         cyc++;
      end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== ref_result(3'd3, a, 4)) begin
         failures++;
         $display("FAIL b2b_first valid=%b result=%h want 1/%h", bus.rsp_valid, bus.rsp_result,
                  ref_result(3'd3, a, 4));
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_rs1 = b; bus.req_shamt = 5'd4;
      #1;
`ifdef FRV_SHIFT_SEQ_B2B_EN
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready got=%b want=1", bus.req_ready);
      end
      @(negedge g_clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_run valid=%b busy=%b want 0/1", bus.rsp_valid, busy);
      end
`else
      checks++;
      if (bus.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_ready got=%b want=0", bus.req_ready);
      end
      @(negedge g_clk);
      bus.rsp_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_bubble busy=%b ready=%b valid=%b want 0/1/0", busy, bus.req_ready, bus.rsp_valid);
      end
      @(negedge g_clk);
      bus.req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_run busy=%b valid=%b want 1/0", busy, bus.rsp_valid);
      end
`endif
      @(negedge g_clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== ref_result(3'd3, b, 4)) begin
         failures++;
         $display("FAIL b2b_second valid=%b result=%h want 1/%h", bus.rsp_valid, bus.rsp_result,
                  ref_result(3'd3, b, 4));
      end
      bus.rsp_ready = 1'b1;
      @(negedge g_clk);
      bus.rsp_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end busy=%b valid=%b want 0/0", busy, bus.rsp_valid);
      end
      $display("TXN b2b a=%h b=%h", a, b);
   endtask

   initial begin
      g_resetn      = 1'b0;
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_rs1   = 32'h0;
      bus.req_shamt = 5'd0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_directed();
      test_stall();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
